// File: rtl/dac_playback_sequencer.sv
// dac_playback_sequencer: streams a BRAM address window to AXIS on trigger. Optional macro TRIG_SYNC_EN adds a 2-flop trigger synchroniser.
module dac_playback_sequencer #(
  parameter int DWIDTH = 64,
  parameter int RD_LAT = 2,
  parameter int CNT_W  = 16
) (
  input  logic                  axis_clk,
  input  logic                  axis_aresetn,
  input  logic [31:0]           cfg_start_addr,
  input  logic [31:0]           cfg_end_addr,
  input  logic [CNT_W-1:0]      cfg_repeat,
  input  logic                  arm,
  input  logic                  trigger,
  input  logic                  abort,
  output logic [31:0]           portA_addr,
  output logic                  portA_en,
  output logic [DWIDTH/8-1:0]   portA_we,
  output logic [DWIDTH-1:0]     portA_wdata,
  input  logic [DWIDTH-1:0]     portA_rdata,
  output logic [DWIDTH-1:0]     axis_tdata,
  output logic                  axis_tvalid,
  output logic                  busy,
  output logic                  done,
  output logic                  err_cfg,
  output logic [CNT_W-1:0]      loop_count
);
  localparam logic [31:0] STEP = 32'(DWIDTH / 8);
  localparam int DRW = $clog2(RD_LAT + 1) + 1;
  typedef enum logic [1:0] {IDLE, ARMED, PLAY, DRAIN} state_t;
  state_t            state_q;
  logic [31:0]       start_q, end_q, addr_q;
  logic [CNT_W-1:0]  rep_q, loop_q;
  logic [DRW-1:0]    drain_q;
  logic [RD_LAT-1:0] vld_q;
  logic              en_q, tvalid_q, done_q, err_q, trig_q, trig_s;
  logic [DWIDTH-1:0] tdata_q;
  logic              trig_rise, cfg_bad, more;
`ifdef TRIG_SYNC_EN
  logic [1:0] sync_q;
  // two-flop synchroniser so an asynchronous trigger can be edge-detected safely
  always_ff @(posedge axis_clk or negedge axis_aresetn)
    if (!axis_aresetn) sync_q <= '0;
    else               sync_q <= {sync_q[0], trigger};
  assign trig_s = sync_q[1];
`else
  assign trig_s = trigger;
`endif
  assign trig_rise = trig_s & ~trig_q;
  assign cfg_bad   = (cfg_end_addr < cfg_start_addr) || |(cfg_start_addr & (STEP - 32'd1)) ||
                     |(cfg_end_addr & (STEP - 32'd1));
  assign more      = (rep_q == '0) || (({1'b0, loop_q} + (CNT_W+1)'(1)) < {1'b0, rep_q});
  assign portA_addr  = addr_q;
  assign portA_en    = en_q;
  assign portA_we    = '0;
  assign portA_wdata = '0;
  assign axis_tdata  = tdata_q;
  assign axis_tvalid = tvalid_q;
  assign busy        = state_q != IDLE;
  assign done        = done_q;
  assign err_cfg     = err_q;
  assign loop_count  = loop_q;
  // control FSM: abort wins over everything, the last word of a pass either wraps or drains
  always_ff @(posedge axis_clk or negedge axis_aresetn)
    if (!axis_aresetn) begin
      state_q <= IDLE;
      start_q <= '0;
      end_q   <= '0;
      rep_q   <= '0;
      addr_q  <= '0;
      en_q    <= 1'b0;
      loop_q  <= '0;
      drain_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (abort) begin
        state_q <= IDLE;
        en_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (arm) begin
            start_q <= cfg_start_addr;
            end_q   <= cfg_end_addr;
            rep_q   <= cfg_repeat;
            loop_q  <= '0;
            err_q   <= cfg_bad;
            addr_q  <= cfg_bad ? addr_q : cfg_start_addr;
            state_q <= cfg_bad ? IDLE : ARMED;
          end
          ARMED: if (trig_rise) begin
            state_q <= PLAY;
            en_q    <= 1'b1;
          end
          PLAY: if (addr_q == end_q) begin
            loop_q <= loop_q + 1'b1;
            if (more) addr_q <= start_q;
            else begin
              state_q <= DRAIN;
              en_q    <= 1'b0;
              drain_q <= DRW'(RD_LAT);
            end
          end else addr_q <= addr_q + STEP;
          DRAIN: if (drain_q == '0) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else drain_q <= drain_q - 1'b1;
          default: state_q <= IDLE;
        endcase
      end
    end
  // read-valid pipeline matched to BRAM latency, then one output register stage
  always_ff @(posedge axis_clk or negedge axis_aresetn)
    if (!axis_aresetn) begin
      trig_q   <= 1'b0;
      vld_q    <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
    end else begin
      trig_q <= trig_s;
      if (abort) begin
        vld_q    <= '0;
        tvalid_q <= 1'b0;
        tdata_q  <= '0;
      end else begin
        vld_q[0] <= en_q;
        for (int i = 1; i < RD_LAT; i++) vld_q[i] <= vld_q[i-1];
        tvalid_q <= vld_q[RD_LAT-1];
        tdata_q  <= vld_q[RD_LAT-1] ? portA_rdata : '0;
      end
    end
endmodule

// File: tb/tb_dac_playback_sequencer.sv
// tb_dac_playback_sequencer: directed checks of the playback sequencer with a 2-cycle BRAM model.
module tb_dac_playback_sequencer;
`ifdef TRIG_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] s_addr = '0, e_addr = '0;
  logic [15:0] rep = '0;
  logic        arm = 1'b0, trigger = 1'b0, abort = 1'b0;
  logic [31:0] addr;
  logic        en, tvalid, busy, done, err;
  logic [7:0]  we;
  logic [63:0] wdata, rdata, tdata, r1 = '0, r2 = '0;
  logic [15:0] lc;
  int          n_cmp = 0, n_err = 0, cyc = 0, n_done = 0, dn_c = 0;
  logic [31:0] en_a[$];
  int          en_c[$], tv_c[$];
  logic [63:0] tv_d[$];

  dac_playback_sequencer dut (
    .axis_clk(clk), .axis_aresetn(rst_n), .cfg_start_addr(s_addr), .cfg_end_addr(e_addr),
    .cfg_repeat(rep), .arm(arm), .trigger(trigger), .abort(abort), .portA_addr(addr),
    .portA_en(en), .portA_we(we), .portA_wdata(wdata), .portA_rdata(rdata),
    .axis_tdata(tdata), .axis_tvalid(tvalid), .busy(busy), .done(done), .err_cfg(err),
    .loop_count(lc));

  always #5 clk = ~clk;

  function automatic logic [63:0] mem(input logic [31:0] a);
    return {~a, a ^ 32'h5A5A_0000};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (en) r1 <= mem(addr);
    r2 <= r1;
  end
  assign rdata = r2;

  always @(negedge clk) begin
    if (en) begin en_a.push_back(addr); en_c.push_back(cyc); end
    if (tvalid) begin tv_d.push_back(tdata); tv_c.push_back(cyc); end
    if (done) begin n_done++; dn_c = cyc; end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr;
    en_a.delete(); en_c.delete(); tv_d.delete(); tv_c.delete();
  endtask

  task automatic do_arm(input logic [31:0] s, input logic [31:0] e, input logic [15:0] r);
    s_addr = s; e_addr = e; rep = r; arm = 1'b1;
    tick;
    arm = 1'b0;
  endtask

  task automatic pulse_trig;
    trigger = 1'b1;
    tick;
    trigger = 1'b0;
    for (int i = 1; i < LAT; i++) tick;
    chk("trig_to_en", en, 1);
  endtask

  task automatic wait_done(input int maxc);
    for (int i = 0; i < maxc && !done; i++) tick;
    chk("done_seen", done, 1);
    tick;
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    tick; tick;
    chk("rst_addr", addr, 0);   chk("rst_en", en, 0);     chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_err", err, 0);     chk("rst_loop", lc, 0);
    rst_n = 1'b1;
    tick;
    // test 1: four-word window played twice
    clr();
    do_arm(32'h0, 32'h18, 16'd2);
    chk("t1_busy_armed", busy, 1); chk("t1_addr_start", addr, 0); chk("t1_en_armed", en, 0);
    pulse_trig();
    wait_done(40);
    chk("t1_reads", en_a.size(), 8);
    chk("t1_beats", tv_d.size(), 8);
    for (int i = 0; i < 8 && i < en_a.size() && i < tv_d.size(); i++) begin
      chk("t1_addr_seq", en_a[i], 32'(8 * (i % 4)));
      chk("t1_addr_gapless", en_c[i], en_c[0] + i);
      chk("t1_beat_latency", tv_c[i], en_c[i] + 3);
      chk("t1_beat_data", tv_d[i], mem(32'(8 * (i % 4))));
    end
    if (en_c.size() == 8) chk("t1_done_after_last", dn_c, en_c[7] + 4);
    chk("t1_loop", lc, 2); chk("t1_ndone", n_done, 1); chk("t1_busy_end", busy, 0);
    chk("t1_tvalid_end", tvalid, 0); chk("t1_tdata_end", tdata, 0);
    // test 2: single-word window, three passes
    clr();
    do_arm(32'h40, 32'h40, 16'd3);
    pulse_trig();
    wait_done(30);
    chk("t2_reads", en_a.size(), 3);
    chk("t2_beats", tv_d.size(), 3);
    for (int i = 0; i < 3 && i < en_a.size() && i < tv_d.size(); i++) begin
      chk("t2_addr", en_a[i], 32'h40);
      chk("t2_gapless", en_c[i], en_c[0] + i);
      chk("t2_data", tv_d[i], mem(32'h40));
    end
    chk("t2_loop", lc, 3); chk("t2_ndone", n_done, 2);
    // test 3: rejected configurations
    clr();
    do_arm(32'h20, 32'h10, 16'd1);
    chk("t3_err_order", err, 1); chk("t3_busy_order", busy, 0); chk("t3_loop_cleared", lc, 0);
    tick;
    chk("t3_err_pulse", err, 0);
    do_arm(32'h4, 32'h18, 16'd1);
    chk("t3_err_align", err, 1); chk("t3_busy_align", busy, 0);
    do_arm(32'h0, 32'h1C, 16'd1);
    chk("t3_err_end_align", err, 1);
    trigger = 1'b1; tick; tick; tick; tick; trigger = 1'b0;
    chk("t3_no_reads", en_a.size(), 0); chk("t3_busy_trig", busy, 0);
    // test 5: trigger level held across arm must not fire
    clr();
    trigger = 1'b1;
    tick; tick; tick; tick;
    do_arm(32'h0, 32'h8, 16'd1);
    for (int i = 0; i < 6; i++) tick;
    chk("t5_still_armed", busy, 1); chk("t5_no_reads", en_a.size(), 0);
    trigger = 1'b0;
    tick; tick; tick; tick;
    chk("t5_low_no_start", en, 0);
    trigger = 1'b1;
    for (int i = 1; i < LAT; i++) begin
      tick;
      chk("t5_early_en", en, 0);
    end
    tick;
    chk("t5_latency", en, 1);
    trigger = 1'b0;
    wait_done(20);
    chk("t5_reads", en_a.size(), 2); chk("t5_loop", lc, 1);
    // test 4: endless loop, abort mid-pass with trigger high
    clr();
    do_arm(32'h0, 32'h18, 16'd0);
    pulse_trig();
    for (int i = 0; i < 400 && lc != 16'd50; i++) tick;
    chk("t4_loop50", lc, 50);
    tick; tick;
    chk("t4_mid_addr", addr, 32'h10); chk("t4_mid_en", en, 1); chk("t4_mid_tvalid", tvalid, 1);
    abort = 1'b1; trigger = 1'b1;
    tick;
    chk("t4_en_off", en, 0); chk("t4_tvalid_off", tvalid, 0); chk("t4_tdata_off", tdata, 0);
    chk("t4_busy_off", busy, 0); chk("t4_loop_hold", lc, 50);
    abort = 1'b0; trigger = 1'b0;
    for (int i = 0; i < 6; i++) tick;
    chk("t4_no_done", n_done, 3); chk("t4_idle_tvalid", tvalid, 0); chk("t4_idle_busy", busy, 0);
    chk("t4_loop_after", lc, 50);
    // test 6: asynchronous reset in the middle of playback
    do_arm(32'h0, 32'h18, 16'd0);
    pulse_trig();
    tick; tick; tick;
    chk("t6_playing", tvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_en", en, 0); chk("t6_tvalid", tvalid, 0); chk("t6_addr", addr, 0);
    chk("t6_tdata", tdata, 0); chk("t6_busy", busy, 0); chk("t6_loop", lc, 0);
    #10 rst_n = 1'b1;
    clr();
    for (int i = 0; i < 6; i++) tick;
    chk("t6_idle_busy", busy, 0); chk("t6_idle_reads", en_a.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
